// File: rtl/vend_frame_deserializer_if.sv
// Handshake and status bundle between the vending frame deserializer and
// the logic around it: serial input side, holding-register output side and
// the frame status flags.
interface vend_frame_deserializer_if #(
   parameter int FIELD_W = 4
);
   logic               shift_en;
   logic               serial_in;
   logic               out_ready;
   logic               out_valid;
   logic [FIELD_W-1:0] item_code;
   logic [FIELD_W-1:0] price;
   logic               frame_err;
   logic               overrun;
   logic               busy;
   logic [4:0]         bit_count;

   // Environment side: upstream shifter plus display/payment consumer.
   modport master (
      output shift_en,
      output serial_in,
      output out_ready,
      input  out_valid,
      input  item_code,
      input  price,
      input  frame_err,
      input  overrun,
      input  busy,
      input  bit_count
   );

   // Deserializer side.
   modport slave (
      input  shift_en,
      input  serial_in,
      input  out_ready,
      output out_valid,
      output item_code,
      output price,
      output frame_err,
      output overrun,
      output busy,
      output bit_count
   );
endinterface

// File: rtl/vend_frame_deserializer.sv
// Vending frame deserializer: rebuilds item code and price from a bit-serial
// frame (item, zero guard, price, zero trailer), rejects frames with nonzero
// pad bits, aborts a stalled partial frame after TIMEOUT idle cycles, and
// holds each good frame in a one-entry valid/ready register.
//
// state | meaning
// IDLE  | no frame in progress; first shift_en samples bit 0
// RECV  | frame partially received; bit_count bits captured so far
module vend_frame_deserializer #(
   parameter int FRAME_BITS = 20,
   parameter int FIELD_W    = 4,
   parameter int TIMEOUT    = 32
) (
   input logic                      clk,
   input logic                      clr,
   vend_frame_deserializer_if.slave bus
);

   // Only item, guard and price bits need storing; trailer bits are just checked.
   localparam int                CAP_W       = 3 * FIELD_W;
   localparam int                IDLE_W      = $clog2(TIMEOUT + 1);
   localparam logic [4:0]        LAST_IDX    = 5'(FRAME_BITS - 1);
   localparam logic [IDLE_W-1:0] TIMEOUT_CNT = IDLE_W'(TIMEOUT);

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   state_t             state_q;
   logic [4:0]         bit_count_q;
   logic [IDLE_W-1:0]  idle_cnt_q;
   logic [CAP_W-1:0]   shift_q;
   logic               pad_bad_q;
   logic               out_valid_q;
   logic [FIELD_W-1:0] item_q;
   logic [FIELD_W-1:0] price_q;
   logic               frame_err_q;
   logic               overrun_q;

   logic [CAP_W-1:0]   shift_d;
   logic               pad_d;
   logic               pad_idx;
   logic [IDLE_W-1:0]  idle_cnt_d;
   logic               hold_free;

   // Capture register with the bit on the wire merged in at its frame index,
   // so the completing edge sees the whole frame including its last bit.
   always_comb begin
      shift_d = shift_q;
      for (int i = 0; i < CAP_W; i++) begin
         if (bit_count_q == 5'(i)) begin
            shift_d[i] = bus.serial_in;
         end
      end
   end

   // Pad check and handshake/timeout helpers for the current cycle.
   always_comb begin
      pad_idx = ((bit_count_q >= 5'(FIELD_W)) && (bit_count_q < 5'(2 * FIELD_W)))
              || (bit_count_q >= 5'(CAP_W));
      pad_d      = pad_bad_q | (pad_idx & bus.serial_in);
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      hold_free  = !out_valid_q || bus.out_ready;
   end

   // Frame FSM, bit counter, idle timer, holding register and status pulses.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= IDLE;
         bit_count_q <= '0;
         idle_cnt_q  <= '0;
         shift_q     <= '0;
         pad_bad_q   <= 1'b0;
         out_valid_q <= 1'b0;
         item_q      <= '0;
         price_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               idle_cnt_q <= '0;
               if (bus.shift_en) begin
                  shift_q     <= shift_d;
                  pad_bad_q   <= 1'b0;
                  bit_count_q <= 5'd1;
                  state_q     <= RECV;
               end
            end
            RECV: begin
               if (bus.shift_en) begin
                  shift_q    <= shift_d;
                  idle_cnt_q <= '0;
                  if (bit_count_q == LAST_IDX) begin
                     state_q     <= IDLE;
                     bit_count_q <= '0;
                     pad_bad_q   <= 1'b0;
                     if (pad_d) begin
                        frame_err_q <= 1'b1;
                     end else if (hold_free) begin
                        out_valid_q <= 1'b1;
                        item_q      <= shift_d[FIELD_W-1:0];
                        price_q     <= shift_d[3*FIELD_W-1:2*FIELD_W];
                     end else begin
                        overrun_q <= 1'b1;
                     end
                  end else begin
                     bit_count_q <= bit_count_q + 5'd1;
                     pad_bad_q   <= pad_d;
                  end
               end else if (idle_cnt_d == TIMEOUT_CNT) begin
                  // Upstream stalled mid-frame: drop the partial frame.
                  frame_err_q <= 1'b1;
                  state_q     <= IDLE;
                  bit_count_q <= '0;
                  pad_bad_q   <= 1'b0;
                  idle_cnt_q  <= '0;
               end else begin
                  idle_cnt_q <= idle_cnt_d;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.item_code = item_q;
   assign bus.price     = price_q;
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
   assign bus.busy      = (state_q == RECV);
   assign bus.bit_count = bit_count_q;

endmodule
